// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared constants, FSM state encodings and helper functions
// for the byte-stream memory loader.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN (enables the trailing
// checksum byte and the CHK state).
package mem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int HDR_BYTES      = 2;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_HDR0  = 3'd1;
   localparam state_t ST_HDR1  = 3'd2;
   localparam state_t ST_DATA  = 3'd3;
   localparam state_t ST_WRITE = 3'd4;
   localparam state_t ST_CHK   = 3'd5;
   localparam state_t ST_DONE  = 3'd6;

   // States in which the loader offers byte_ready to the source.
   function automatic logic accepts_bytes(input state_t s);
      logic r;
      case (s)
         ST_HDR0, ST_HDR1, ST_DATA, ST_CHK: r = 1'b1;
         default:                           r = 1'b0;
      endcase
      return r;
   endfunction

   // Running XOR used for the optional trailing checksum.
   function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/mem_loader_word_packer.sv
// word_packer: shifts bytes into a 32-bit word, MSB first (the first byte of a
// word ends up in [31:23+1]). word_full means the next shift completes a word.
module word_packer
   import mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0] index_r;

   // Assembly register and byte index; clear restarts word alignment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word    <= 32'h0000_0000;
         index_r <= 2'd0;
      end else if (clear) begin
         word    <= 32'h0000_0000;
         index_r <= 2'd0;
      end else if (shift_en) begin
         word    <= {word[23:0], byte_in};
         index_r <= index_r + 2'd1;
      end else begin
         word    <= word;
         index_r <= index_r;
      end
   end

   assign word_full = (index_r == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
// mem_loader: receives COUNT_HI, COUNT_LO, then N big-endian 32-bit words over
// a valid/ready byte stream and writes them through the memory override port.
// busy holds the CPU off during a load; done releases it.
// Optional feature macro: MEM_LOADER_CHECKSUM_EN -- one trailing byte equal to
// the XOR of all data bytes is checked in a CHK state; mismatch raises error.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int START_ADDR = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  overide,
   output logic [ADDR_WIDTH-1:0] overide_address,
   output logic [DATA_WIDTH-1:0] overide_data_in,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

   state_t                state_r, state_nxt_s;
   logic [15:0]           count_r, count_nxt_s;
   logic [7:0]            hdr_hi_r, hdr_hi_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_nxt_s;
   logic [ADDR_WIDTH:0]   words_nxt_s;
   logic [ADDR_WIDTH:0]   words_inc_s;
   logic                  busy_nxt_s, done_nxt_s, error_nxt_s;
   logic                  xfer_s;
   logic [15:0]           n_s;
   logic                  pk_clear_s, pk_shift_s, pk_full_s;
   logic [31:0]           pk_word_s;
`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0]            cks_r, cks_nxt_s;
`endif

   assign xfer_s      = byte_valid && byte_ready;
   assign n_s         = {hdr_hi_r, byte_data};
   assign words_inc_s = words_loaded + 1'b1;

   word_packer u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (pk_clear_s),
      .shift_en  (pk_shift_s),
      .byte_in   (byte_data),
      .word      (pk_word_s),
      .word_full (pk_full_s)
   );

   // Next-state and datapath decisions for the load sequence.
   always_comb begin
      state_nxt_s  = state_r;
      count_nxt_s  = count_r;
      hdr_hi_nxt_s = hdr_hi_r;
      addr_nxt_s   = overide_address;
      words_nxt_s  = words_loaded;
      busy_nxt_s   = busy;
      done_nxt_s   = done;
      error_nxt_s  = error;
      pk_clear_s   = 1'b0;
      pk_shift_s   = 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      cks_nxt_s    = cks_r;
`endif
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt_s = ST_HDR0;
               done_nxt_s  = 1'b0;
               error_nxt_s = 1'b0;
               words_nxt_s = '0;
               busy_nxt_s  = 1'b1;
               pk_clear_s  = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
               cks_nxt_s   = 8'h00;
`endif
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_HDR0: begin
            if (xfer_s) begin
               hdr_hi_nxt_s = byte_data;
               state_nxt_s  = ST_HDR1;
            end else begin
               state_nxt_s  = ST_HDR0;
            end
         end
         ST_HDR1: begin
            if (xfer_s) begin
               count_nxt_s = n_s;
               if ({1'b0, n_s} > MAX_WORDS) begin
                  error_nxt_s = 1'b1;
                  busy_nxt_s  = 1'b0;
                  done_nxt_s  = 1'b1;
                  state_nxt_s = ST_DONE;
               end else if (n_s == 16'd0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                  state_nxt_s = ST_CHK;
`else
                  busy_nxt_s  = 1'b0;
                  done_nxt_s  = 1'b1;
                  state_nxt_s = ST_DONE;
`endif
               end else begin
                  addr_nxt_s  = ADDR_WIDTH'(START_ADDR);
                  pk_clear_s  = 1'b1;
                  state_nxt_s = ST_DATA;
               end
            end else begin
               state_nxt_s = ST_HDR1;
            end
         end
         ST_DATA: begin
            if (xfer_s) begin
               pk_shift_s = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
               cks_nxt_s  = xor_acc(cks_r, byte_data);
`endif
               if (pk_full_s) begin
                  state_nxt_s = ST_WRITE;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_WRITE: begin
            words_nxt_s = words_inc_s;
            // Address register width makes 2**ADDR_WIDTH-1 wrap to 0.
            addr_nxt_s  = overide_address + 1'b1;
            if (16'(words_inc_s) == count_r) begin
`ifdef MEM_LOADER_CHECKSUM_EN
               state_nxt_s = ST_CHK;
`else
               busy_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_DONE;
`endif
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
`ifdef MEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (xfer_s) begin
               error_nxt_s = (byte_data != cks_r);
               busy_nxt_s  = 1'b0;
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_CHK;
            end
         end
`endif
         default: begin
            state_nxt_s = ST_IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs; strobes are decoded from the
   // next state so overide is high exactly for the WRITE cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= ST_IDLE;
         count_r         <= 16'h0000;
         hdr_hi_r        <= 8'h00;
         overide_address <= '0;
         words_loaded    <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         byte_ready      <= 1'b0;
         overide         <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
         cks_r           <= 8'h00;
`endif
      end else begin
         state_r         <= state_nxt_s;
         count_r         <= count_nxt_s;
         hdr_hi_r        <= hdr_hi_nxt_s;
         overide_address <= addr_nxt_s;
         words_loaded    <= words_nxt_s;
         busy            <= busy_nxt_s;
         done            <= done_nxt_s;
         error           <= error_nxt_s;
         byte_ready      <= accepts_bytes(state_nxt_s);
         overide         <= (state_nxt_s == ST_WRITE);
`ifdef MEM_LOADER_CHECKSUM_EN
         cks_r           <= cks_nxt_s;
`endif
      end
   end

   assign overide_data_in = pk_word_s;

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: table-driven streams with a write scoreboard. Two loader
// instances share all inputs: one at START_ADDR=0, one at START_ADDR=510 to
// exercise the address wrap.
module tb_mem_loader;

`ifdef MEM_LOADER_CHECKSUM_EN
   localparam bit CKS = 1'b1;
`else
   localparam bit CKS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, start, byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready, overide, busy, done, error;
   logic [8:0]  overide_address;
   logic [31:0] overide_data_in;
   logic [9:0]  words_loaded;
   logic        byte_ready2, overide2, busy2, done2, error2;
   logic [8:0]  overide_address2;
   logic [31:0] overide_data_in2;
   logic [9:0]  words_loaded2;

   always #5 clk = ~clk;

   mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .START_ADDR(0)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .overide(overide),
      .overide_address(overide_address), .overide_data_in(overide_data_in),
      .busy(busy), .done(done), .error(error), .words_loaded(words_loaded));

   mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .START_ADDR(510)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready2), .overide(overide2),
      .overide_address(overide_address2), .overide_data_in(overide_data_in2),
      .busy(busy2), .done(done2), .error(error2), .words_loaded(words_loaded2));

   typedef struct {
      int                 nb;
      logic [0:15][7:0]   b;
      bit                 gaps;
      bit                 bad_cks;
      bit                 cnt_err;
      int                 words;
   } vec_t;

   vec_t        vecs[8];
   logic [40:0] exp_q[$], exp2_q[$], obs_q[$], obs2_q[$];
   int          tests = 0;
   int          fails = 0;
   int          long_pulse = 0;
   logic        ov_prev = 1'b0, ov2_prev = 1'b0;

   // Capture every override write and flag strobes longer than one cycle.
   always @(negedge clk) begin
      if (reset_n) begin
         if (overide)  obs_q.push_back({overide_address, overide_data_in});
         if (overide2) obs2_q.push_back({overide_address2, overide_data_in2});
         if ((overide && ov_prev) || (overide2 && ov2_prev)) long_pulse <= long_pulse + 1;
         ov_prev  <= overide;
         ov2_prev <= overide2;
      end else begin
         ov_prev  <= 1'b0;
         ov2_prev <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int nb, input logic [127:0] bytes, input bit gaps,
                               input bit bad, input bit cerr, input int words);
      vec_t v;
      v.nb = nb; v.b = bytes; v.gaps = gaps; v.bad_cks = bad; v.cnt_err = cerr; v.words = words;
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int tmo;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
         end
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      tmo = 0;
      while (!byte_ready && tmo < 50) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 50) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: got byte_ready=0 for %0d cycles expected 1", tmo);
      end
      @(posedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [7:0] sq[$];
      logic [7:0] cks;
      int         n, t;
      logic       exp_err;
      n = {v.b[0], v.b[1]};
      cks = 8'h00;
      for (int i = 0; i < v.nb; i++) sq.push_back(v.b[i]);
      if (n <= 512) begin
         for (int w = 0; w < n; w++) begin
            exp_q.push_back({9'(w), v.b[2+4*w], v.b[3+4*w], v.b[4+4*w], v.b[5+4*w]});
            exp2_q.push_back({9'(510 + w), v.b[2+4*w], v.b[3+4*w], v.b[4+4*w], v.b[5+4*w]});
         end
         for (int i = 2; i < v.nb; i++) cks = cks ^ v.b[i];
         if (CKS) sq.push_back(v.bad_cks ? (cks ^ 8'h01) : cks);
      end
      exp_err = v.cnt_err | (CKS & v.bad_cks);

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check($sformatf("v%0d busy_after_start", idx), {busy, busy2}, 2'b11);
      check($sformatf("v%0d ready_in_hdr0", idx), {byte_ready, byte_ready2}, 2'b11);

      for (int i = 0; i < sq.size(); i++) begin
         send_byte(sq[i], v.gaps);
         if (i >= 2 && i < 2 + 4*n && n <= 512 && ((i - 2) % 4) == 3) begin
            @(negedge clk);
            check($sformatf("v%0d write_latency", idx), {overide, overide2, byte_ready}, 3'b110);
         end
      end
      @(negedge clk);
      byte_valid = 1'b0;

      t = 0;
      while (!(done && done2) && t < 40) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("v%0d done", idx), {done, done2, busy, busy2, byte_ready}, 5'b11000);
      check($sformatf("v%0d error", idx), {error, error2}, {exp_err, exp_err});
      check($sformatf("v%0d words_loaded", idx), words_loaded, 64'(v.words));
      check($sformatf("v%0d words_loaded2", idx), words_loaded2, 64'(v.words));
      check($sformatf("v%0d nwrites", idx), obs_q.size(), exp_q.size());
      check($sformatf("v%0d nwrites2", idx), obs2_q.size(), exp2_q.size());
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
         check($sformatf("v%0d write%0d", idx, k), obs_q[k], exp_q[k]);
      for (int k = 0; k < exp2_q.size() && k < obs2_q.size(); k++)
         check($sformatf("v%0d write2_%0d", idx, k), obs2_q[k], exp2_q[k]);
      exp_q.delete(); exp2_q.delete(); obs_q.delete(); obs2_q.delete();
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

      vecs[0] = mk(10, {80'h0002_DEADBEEF_01234567, 48'h0}, 1'b0, 1'b0, 1'b0, 2);
      vecs[1] = mk(10, {80'h0002_DEADBEEF_01234567, 48'h0}, 1'b1, 1'b0, 1'b0, 2);
      vecs[2] = mk(2,  {16'h0201, 112'h0},                  1'b0, 1'b0, 1'b1, 0);
      vecs[3] = mk(2,  {16'h0000, 112'h0},                  1'b0, 1'b0, 1'b0, 0);
      vecs[4] = mk(14, {112'h0003_A0A1A2A3_B0B1B2B3_C0C1C2C3, 16'h0}, 1'b1, 1'b0, 1'b0, 3);
      vecs[5] = mk(6,  {48'h0001_11223344, 80'h0},          1'b0, 1'b0, 1'b0, 1);
      vecs[6] = mk(6,  {48'h0001_11223344, 80'h0},          1'b0, 1'b1, 1'b0, 1);
      vecs[7] = mk(10, {80'h0002_DEADBEEF_01234567, 48'h0}, 1'b0, 1'b0, 1'b0, 2);

      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, error, byte_ready, overide, words_loaded}, 15'h0);
      check("reset_outputs2", {busy2, done2, error2, byte_ready2, overide2, overide_address2}, 14'h0);
      reset_n = 1'b1;

      // Abandon a load two bytes into the data phase.
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      send_byte(8'h00, 1'b0);
      send_byte(8'h01, 1'b0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      check("busy_mid_data", {busy, byte_ready}, 2'b11);
      #2 reset_n = 1'b0;
      #1;
      check("reset_immediate", {overide, busy, byte_ready, overide2, busy2, byte_ready2}, 6'b0);
      @(negedge clk);
      byte_valid = 1'b0;
      reset_n = 1'b1;
      check("no_write_before_reset", obs_q.size() + obs2_q.size(), 64'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      check("single_cycle_pulses", long_pulse, 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream program/data loader for the 512x32 main memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into memory through its override write port (override, override address, override data).
- Runs before the CPU is released: `busy` holds the CPU off, and `done` releases it.

Parameters:
- DATA_WIDTH, 32, memory word width; must be 32 (four bytes per word).
- ADDR_WIDTH, 9, memory address width; depth is 2**ADDR_WIDTH.
- START_ADDR, 0, address of the first word written.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless IDLE or DONE.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte; a transfer occurs when byte_valid && byte_ready at the clk edge.
- overide  out  1  override write strobe to memory.
- overide_address  out  ADDR_WIDTH  override write address.
- overide_data_in  out  DATA_WIDTH  override write data.
- busy  out  1  load in progress.
- done  out  1  load finished; held until the next start.
- error  out  1  header or checksum fault; held until the next start.
- words_loaded  out  ADDR_WIDTH+1  count of words written this load.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs go to 0; overide drops in the same instant.
  - Counters, address and assembly register clear.
  - Reset mid-load abandons the load; words already written stay in memory.
- Stream format: COUNT_HI, COUNT_LO (16-bit word count N, big-endian), then N x 4 data bytes, MSB first.
- IDLE:
  - byte_ready=0.
  - start -> HDR0; clears done, error and words_loaded; sets busy=1.
- HDR0:
  - byte_ready=1.
  - On a transfer, latch the high count byte -> HDR1.
- HDR1:
  - byte_ready=1.
  - On a transfer, form N.
  - If N > 2**ADDR_WIDTH: error=1 -> DONE, no writes.
  - If N==0: -> CHK when CHECKSUM_EN is defined, otherwise -> DONE.
  - Otherwise -> DATA with byte index 0 and address START_ADDR.
- DATA:
  - byte_ready=1.
  - Each transfer shifts the byte into the assembly register (first byte lands in [31:24]).
  - The 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0.
  - overide=1 with the registered address and word; words_loaded increments.
  - Address increments modulo 2**ADDR_WIDTH (wraps 511->0).
  - If words_loaded reaches N -> CHK/DONE, otherwise -> DATA.
- Latency: 4th-byte handshake at edge k gives overide high during cycle k+1. Sustained rate is 5 cycles per word.
- DONE:
  - busy=0, done=1, byte_ready=0.
  - start -> HDR0 (restart allowed).
- start while busy is ignored.
- byte_valid while byte_ready=0 is not consumed; the source must hold its byte.
- overide is never asserted outside WRITE.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined:
  - CHK state accepts one trailing byte.
  - Expected value is the XOR of every byte after the header.
  - Mismatch sets error=1. Either way the next state is DONE.
  - Words already written are not rolled back.
- Undefined: no CHK state; the last WRITE goes straight to DONE, and error is raised only by the count check.

Decomposition:
- Package mem_loader_pkg holds:
  - state enumeration (IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE);
  - BYTES_PER_WORD=4;
  - HDR_BYTES=2.
- Sub-module word_packer: shift-in byte assembler with a 2-bit index and word_full flag; the FSM owns the handshake and addressing.

Test Plan:
- Reset during DATA after 2 bytes -> overide, busy and byte_ready read 0 immediately. A new start then loads a fresh stream correctly from START_ADDR.
- start; bytes 00 02 DE AD BE EF 01 23 45 67, source always valid:
  - overide pulses at address 0 with 0xDEADBEEF, then at address 1 with 0x01234567;
  - each pulse is exactly 1 cycle, one cycle after the 4th byte;
  - words_loaded=2, done=1, error=0.
- Same stream with byte_valid randomly deasserted and held bytes -> identical writes; no byte dropped or duplicated.
- Header 02 01 (N=513) -> error=1 and done=1, zero overide pulses. Header 00 00 -> done with no writes.
- START_ADDR=510, N=3 -> writes at 510, 511, 0.
- With MEM_LOADER_CHECKSUM_EN, stream 00 01 11 22 33 44 + checksum 0x44 -> error=0. Same stream with checksum 0x45 -> error=1, and the word 0x11223344 is still written.
